placar_acumulador: RTL and testbench

Score register for one team of the basketball scoreboard: takes a point value (1–3) and an add/subtract switch, applies it to a 7-bit binary score on a confirm-button press, and saturates at 0 and `MAX_PONTOS` instead of wrapping. It is the consumer of the underflow condition "subtract mode and B > score": it applies the update, clamps, and flags the limit. Each new score is then converted to two BCD digits with a sequential shift-add-3 engine, ready for the 7-segment decoders.

---
 rtl/placar_acumulador.sv | 143 ++++++++++++++
 tb/tb_placar_acumulador.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/placar_acumulador.sv
// placar_acumulador: saturating team score register with sequential binary-to-BCD conversion.
// Optional undo of the last update when PLACAR_DESFAZ_EN is defined.
module placar_acumulador #(
   parameter int MAX_PONTOS = 99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       botaoConfirma,
   input  logic       chavePN,
   input  logic [1:0] B,
`ifdef PLACAR_DESFAZ_EN
   input  logic       botaoDesfaz,
`endif
   output logic [6:0] pontos,
   output logic [3:0] dezena,
   output logic [3:0] unidade,
   output logic       bcdValido,
   output logic       ocupado,
   output logic       erroLimite
);
   typedef enum logic {IDLE, CONV} estado_t;
   localparam logic [6:0] MAX7 = 7'(MAX_PONTOS);
   estado_t     estado_q, estado_d;
   logic        botao_ant_q, botao_ant_d;
   logic [6:0]  pontos_q, pontos_d;
   logic [3:0]  dezena_q, dezena_d, unidade_q, unidade_d;
   logic        bcd_valido_q, bcd_valido_d, ocupado_q, ocupado_d, erro_q, erro_d;
   logic [2:0]  passo_q, passo_d;
   logic [14:0] sr_q, sr_d, sr_aj, sr_desl;
   logic [7:0]  soma;
   logic [6:0]  novo, carga;
   logic        press, abaixo, acima, inicia;
`ifdef PLACAR_DESFAZ_EN
   logic        desfaz_ant_q, desfaz_ant_d, desfaz_valido_q, desfaz_valido_d, desfaz;
   logic [6:0]  pontos_ant_q, pontos_ant_d;
`endif
   always_comb begin
      estado_d     = estado_q;
      botao_ant_d  = botaoConfirma;
      pontos_d     = pontos_q;
      dezena_d     = dezena_q;
      unidade_d    = unidade_q;
      bcd_valido_d = bcd_valido_q;
      ocupado_d    = ocupado_q;
      erro_d       = 1'b0;
      passo_d      = passo_q;
      sr_d         = sr_q;
      carga        = pontos_q;
      inicia       = 1'b0;
`ifdef PLACAR_DESFAZ_EN
      desfaz_ant_d    = botaoDesfaz;
      desfaz_valido_d = desfaz_valido_q;
      pontos_ant_d    = pontos_ant_q;
      desfaz          = botaoDesfaz & ~desfaz_ant_q;
`endif
      press  = botaoConfirma & ~botao_ant_q;
      soma   = {1'b0, pontos_q} + {6'd0, B};
      abaixo = {5'd0, B} > pontos_q;
      acima  = soma > {1'b0, MAX7};
      novo   = chavePN ? (abaixo ? 7'd0 : pontos_q - {5'd0, B}) : (acima ? MAX7 : soma[6:0]);
      // shift-add-3: correct each BCD nibble before it doubles
      sr_aj          = sr_q;
      sr_aj[14:11]   = sr_q[14:11] >= 4'd5 ? sr_q[14:11] + 4'd3 : sr_q[14:11];
      sr_aj[10:7]    = sr_q[10:7] >= 4'd5 ? sr_q[10:7] + 4'd3 : sr_q[10:7];
      sr_desl        = sr_aj << 1;
      if (estado_q == IDLE) begin
         if (press && B != 2'd0) begin
            pontos_d = novo;
            erro_d   = chavePN ? abaixo : acima;
            carga    = novo;
            inicia   = 1'b1;
`ifdef PLACAR_DESFAZ_EN
            pontos_ant_d    = pontos_q;
            desfaz_valido_d = 1'b1;
         end else if (desfaz && desfaz_valido_q && !press) begin
            pontos_d        = pontos_ant_q;
            carga           = pontos_ant_q;
            desfaz_valido_d = 1'b0;
            inicia          = 1'b1;
`endif
         end
      end else begin
         sr_d    = sr_desl;
         passo_d = passo_q + 3'd1;
         if (passo_q == 3'd6) begin
            estado_d     = IDLE;
            passo_d      = 3'd0;
            dezena_d     = sr_desl[14:11];
            unidade_d    = sr_desl[10:7];
            bcd_valido_d = 1'b1;
            ocupado_d    = 1'b0;
         end
      end
      if (inicia) begin
         estado_d     = CONV;
         sr_d         = {8'd0, carga};
         passo_d      = 3'd0;
         ocupado_d    = 1'b1;
         bcd_valido_d = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q     <= IDLE;
         botao_ant_q  <= 1'b1;
         pontos_q     <= 7'd0;
         dezena_q     <= 4'd0;
         unidade_q    <= 4'd0;
         bcd_valido_q <= 1'b1;
         ocupado_q    <= 1'b0;
         erro_q       <= 1'b0;
         passo_q      <= 3'd0;
         sr_q         <= 15'd0;
`ifdef PLACAR_DESFAZ_EN
         desfaz_ant_q    <= 1'b1;
         desfaz_valido_q <= 1'b0;
         pontos_ant_q    <= 7'd0;
`endif
      end else begin
         estado_q     <= estado_d;
         botao_ant_q  <= botao_ant_d;
         pontos_q     <= pontos_d;
         dezena_q     <= dezena_d;
         unidade_q    <= unidade_d;
         bcd_valido_q <= bcd_valido_d;
         ocupado_q    <= ocupado_d;
         erro_q       <= erro_d;
         passo_q      <= passo_d;
         sr_q         <= sr_d;
`ifdef PLACAR_DESFAZ_EN
         desfaz_ant_q    <= desfaz_ant_d;
         desfaz_valido_q <= desfaz_valido_d;
         pontos_ant_q    <= pontos_ant_d;
`endif
      end
   end
   assign pontos     = pontos_q;
   assign dezena     = dezena_q;
   assign unidade    = unidade_q;
   assign bcdValido  = bcd_valido_q;
   assign ocupado    = ocupado_q;
   assign erroLimite = erro_q;
endmodule

// File: tb/tb_placar_acumulador.sv
// tb_placar_acumulador: random and directed checks of placar_acumulador against a decimal score model.
module tb_placar_acumulador;
   localparam int MAX = 99;
   logic       clk = 1'b0, reset = 1'b1, botaoConfirma = 1'b0, chavePN = 1'b0, botaoDesfaz = 1'b0;
   logic [1:0] B = 2'd0;
   logic [6:0] pontos;
   logic [3:0] dezena, unidade;
   logic       bcdValido, ocupado, erroLimite;
   int checks = 0, failures = 0;
   int score = 0, score_ant = 0;
   bit undo_ok = 1'b0;
   placar_acumulador #(.MAX_PONTOS(MAX)) dut (
      .clk(clk), .reset(reset), .botaoConfirma(botaoConfirma), .chavePN(chavePN), .B(B),
`ifdef PLACAR_DESFAZ_EN
      .botaoDesfaz(botaoDesfaz),
`endif
      .pontos(pontos), .dezena(dezena), .unidade(unidade),
      .bcdValido(bcdValido), .ocupado(ocupado), .erroLimite(erroLimite)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic check_idle_reset(input string tag);
      check({tag, "_pontos"}, pontos, 0);
      check({tag, "_dezena"}, dezena, 0);
      check({tag, "_unidade"}, unidade, 0);
      check({tag, "_bcdValido"}, bcdValido, 1);
      check({tag, "_ocupado"}, ocupado, 0);
      check({tag, "_erro"}, erroLimite, 0);
   endtask
   task automatic do_reset(input bit held);
      @(negedge clk);
      reset = 1'b1;
      botaoConfirma = held;
      botaoDesfaz = 1'b0;
      @(negedge clk);
      check_idle_reset("reset");
      reset = 1'b0;
      score = 0;
      undo_ok = 1'b0;
   endtask
   // called at the falling edge right after the accepting edge
   task automatic wait_conv(input int old_score, input bit glitch);
      int cnt = 1;
      while (ocupado && cnt <= 20) begin
         check("dez_hold", dezena, old_score / 10);
         check("uni_hold", unidade, old_score % 10);
         if (glitch && cnt == 3) botaoConfirma = 1'b1;
         @(negedge clk);
         cnt++;
         if (cnt == 2) check("erro_clear", erroLimite, 0);
      end
      check("busy_cycles", cnt - 1, 7);
      check("dezena", dezena, score / 10);
      check("unidade", unidade, score % 10);
      check("bcdValido_end", bcdValido, 1);
      check("pontos_end", pontos, score);
      if (glitch) botaoConfirma = 1'b0;
   endtask
   task automatic press(input int b, input bit pn, input bit hold, input bit glitch, input bit with_undo);
      int old = score;
      bit clamp = 1'b0;
      @(negedge clk);
      B = 2'(b);
      chavePN = pn;
      botaoConfirma = 1'b1;
      botaoDesfaz = with_undo;
      if (b != 0) begin
         score_ant = old;
         undo_ok = 1'b1;
         if (pn) begin
            if (b > score) begin clamp = 1'b1; score = 0; end
            else score -= b;
         end else begin
            if (score + b > MAX) begin clamp = 1'b1; score = MAX; end
            else score += b;
         end
      end
      @(negedge clk);
      check("pontos", pontos, score);
      check("erroLimite", erroLimite, clamp);
      check("ocupado_start", ocupado, b != 0);
      check("bcdValido_start", bcdValido, b == 0);
      if (!hold) botaoConfirma = 1'b0;
      botaoDesfaz = 1'b0;
      B = 2'($urandom);
      chavePN = 1'($urandom);
      if (b != 0) wait_conv(old, glitch);
      if (hold) begin
         repeat (12) @(negedge clk);
         check("held_once", pontos, score);
         check("held_idle", ocupado, 0);
         botaoConfirma = 1'b0;
      end
      @(negedge clk);
   endtask
   task automatic undo();
      int old = score;
      bit exp = undo_ok;
      @(negedge clk);
      botaoDesfaz = 1'b1;
      if (exp) begin score = score_ant; undo_ok = 1'b0; end
      @(negedge clk);
      botaoDesfaz = 1'b0;
      check("undo_pontos", pontos, score);
      check("undo_ocupado", ocupado, exp);
      check("undo_erro", erroLimite, 0);
      if (exp) wait_conv(old, 1'b0);
      @(negedge clk);
   endtask
   initial begin
      do_reset(1'b0);
      press(3, 0, 0, 0, 0);
      do_reset(1'b0);
      repeat (32) press(3, 0, 0, 0, 0);
      press(2, 0, 0, 0, 0);
      check("score98", pontos, 98);
      press(3, 0, 0, 0, 0);
      press(1, 0, 0, 0, 0);
      do_reset(1'b0);
      press(1, 0, 0, 0, 0);
      press(2, 1, 0, 0, 0);
      press(2, 0, 0, 0, 0);
      press(2, 1, 0, 0, 0);
      press(2, 0, 1, 0, 0);
      press(1, 0, 0, 1, 0);
      press(0, 0, 0, 0, 0);
      press(1, 1, 0, 0, 0);
      press(1, 1, 0, 0, 0);
      do_reset(1'b1);
      repeat (3) @(negedge clk);
      check("held_reset_pontos", pontos, 0);
      check("held_reset_ocupado", ocupado, 0);
      botaoConfirma = 1'b0;
      @(negedge clk);
      botaoConfirma = 1'b1;
      B = 2'd2;
      chavePN = 1'b0;
      @(negedge clk);
      botaoConfirma = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_idle_reset("midreset");
      reset = 1'b0;
      score = 0;
      undo_ok = 1'b0;
      press(3, 0, 0, 0, 0);
`ifdef PLACAR_DESFAZ_EN
      do_reset(1'b0);
      repeat (15) press(3, 0, 0, 0, 0);
      press(2, 0, 0, 0, 0);
      check("score47", pontos, 47);
      undo();
      check("undo45_d", dezena, 4);
      check("undo45_u", unidade, 5);
      undo();
      check("undo_twice", pontos, 45);
      press(1, 0, 0, 0, 1);
      check("confirm_wins", pontos, 46);
`endif
      for (int i = 0; i < 150; i++) begin
`ifdef PLACAR_DESFAZ_EN
         if ($urandom_range(0, 4) == 0) undo();
         else
`endif
         press(int'($urandom_range(0, 3)), 1'($urandom), 0, 0, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
